// File: rtl/p2_video_scan.sv
// p2_video_scan: raster scan-out engine for the 1152x900 monochrome frame buffer.
// Prefetches one 16-bit VRAM word per 16 pixels over read port 1, shifts it out
// MSB-first and generates hsync/vsync/blank and a once-per-frame vblank pulse.
module p2_video_scan #(
   parameter int unsigned H_ACTIVE = 1152,
   parameter int unsigned H_FP     = 40,
   parameter int unsigned H_SYNC   = 128,
   parameter int unsigned H_BP     = 184,
   parameter int unsigned V_ACTIVE = 900,
   parameter int unsigned V_FP     = 2,
   parameter int unsigned V_SYNC   = 4,
   parameter int unsigned V_BP     = 31,
   parameter int unsigned RD_LAT   = 1,
   parameter bit          HS_POL   = 1'b0,
   parameter bit          VS_POL   = 1'b0
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        video_en,
   output logic        rd_en,
   output logic [16:0] rd_addr,
   input  logic [15:0] rd_data,
   output logic        pixel,
   output logic        hsync,
   output logic        vsync,
   output logic        blank,
   output logic        vblank_irq
);

   localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
   localparam int unsigned WORDS   = H_ACTIVE / 16;
   localparam int unsigned HW      = $clog2(H_TOTAL);
   localparam int unsigned VW      = $clog2(V_TOTAL);

   localparam logic [HW-1:0] H_ONE    = HW'(1);
   localparam logic [HW-1:0] H_LAST   = HW'(H_TOTAL - 1);
   localparam logic [HW-1:0] H_RST    = HW'(H_TOTAL - 16);
   localparam logic [HW-1:0] H_ACT    = HW'(H_ACTIVE);
   localparam logic [HW-1:0] H_WK_MAX = HW'(H_ACTIVE - 24);
   localparam logic [HW-1:0] H_W0     = HW'(H_TOTAL - 8);
   localparam logic [HW-1:0] H_HS_ON  = HW'(H_ACTIVE + H_FP);
   localparam logic [HW-1:0] H_HS_OFF = HW'(H_ACTIVE + H_FP + H_SYNC);
   localparam logic [VW-1:0] V_ONE    = VW'(1);
   localparam logic [VW-1:0] V_LAST   = VW'(V_TOTAL - 1);
   localparam logic [VW-1:0] V_ACT    = VW'(V_ACTIVE);
   localparam logic [VW-1:0] V_ACT_M1 = VW'(V_ACTIVE - 1);
   localparam logic [VW-1:0] V_VS_ON  = VW'(V_ACTIVE + V_FP);
   localparam logic [VW-1:0] V_VS_OFF = VW'(V_ACTIVE + V_FP + V_SYNC);
   localparam logic [15:0]   W_STEP   = 16'(WORDS);

   logic [HW-1:0]     h, h_nxt;
   logic [VW-1:0]     v, v_nxt;
   logic [15:0]       line_base;
   logic [15:0]       fetch_word;
   logic              fetch;
   logic [RD_LAT-1:0] cap_pipe;
   logic [15:0]       hold;
   logic [15:0]       shift;
   logic              en_q;
   logic              active, in_hs, in_vs, pix_bit, en_eff;

   // next raster position: h wraps into v, v wraps at frame end
   always_comb begin
      h_nxt = h + H_ONE;
      v_nxt = v;
      if (h == H_LAST) begin
         h_nxt = '0;
         v_nxt = (v == V_LAST) ? '0 : v + V_ONE;
      end
   end

   // fetch decision is made on the next position so rd_en is high exactly at h=16k-8
   always_comb begin
      fetch      = 1'b0;
      fetch_word = line_base;
      if (v_nxt < V_ACT && h_nxt[3:0] == 4'd8 && h_nxt <= H_WK_MAX) begin
         fetch      = 1'b1;
         fetch_word = line_base + 16'(h_nxt[HW-1:4]) + 16'd1;
      end else if (h_nxt == H_W0 && (v == V_LAST || v < V_ACT_M1)) begin
         fetch      = 1'b1;
         fetch_word = (v == V_LAST) ? '0 : line_base + W_STEP;
      end
   end

   // raster counters, line base word index and VRAM read request
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         h         <= H_RST;
         v         <= V_LAST;
         line_base <= '0;
         rd_en     <= 1'b0;
         rd_addr   <= '0;
      end else begin
         h <= h_nxt;
         v <= v_nxt;
         if (h == H_LAST) begin
            if (v == V_LAST)
               line_base <= '0;
            else if (v < V_ACT_M1)
               line_base <= line_base + W_STEP;
         end
         rd_en <= fetch;
         if (fetch)
            rd_addr <= {fetch_word, 1'b0};
      end
   end

   // read-latency pipeline: latch rd_data exactly RD_LAT clocks after rd_en
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         cap_pipe <= '0;
         hold     <= '0;
      end else begin
         cap_pipe[0] <= rd_en;
         for (int unsigned i = 1; i < RD_LAT; i++)
            cap_pipe[i] <= cap_pipe[i-1];
         if (cap_pipe[RD_LAT-1])
            hold <= rd_data;
      end
   end

   // Pixel for the current h is taken before the shift register updates: on a
   // word boundary that is hold[15], otherwise shift[14], so the registered
   // pixel lines up with blank/hsync/vsync (all one clock behind the counters).
   always_comb begin
      active  = (h < H_ACT) && (v < V_ACT);
      in_hs   = (h >= H_HS_ON) && (h < H_HS_OFF);
      in_vs   = (v >= V_VS_ON) && (v < V_VS_OFF);
      pix_bit = (h[3:0] == 4'd0) ? hold[15] : shift[14];
      en_eff  = (h == '0 && v == '0) ? video_en : en_q;
   end

   // serialiser: reload every 16 active pixels, otherwise shift MSB-first
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)
         shift <= '0;
      else if (active && h[3:0] == 4'd0)
         shift <= hold;
      else
         shift <= {shift[14:0], 1'b0};
   end

   // display enable sampled only at frame start to avoid mid-frame tearing
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)
         en_q <= 1'b0;
      else if (h == '0 && v == '0)
         en_q <= video_en;
   end

   // registered output stage: pixel, blank, syncs and vblank pulse share alignment
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         pixel      <= 1'b0;
         blank      <= 1'b1;
         hsync      <= ~HS_POL;
         vsync      <= ~VS_POL;
         vblank_irq <= 1'b0;
      end else begin
         pixel      <= active & en_eff & pix_bit;
         blank      <= ~active;
         hsync      <= in_hs ? HS_POL : ~HS_POL;
         vsync      <= in_vs ? VS_POL : ~VS_POL;
         vblank_irq <= (v == V_ACT) && (h == '0);
      end
   end

endmodule

// File: tb/tb_p2_video_scan.sv
// tb_p2_video_scan: reduced-geometry bench for p2_video_scan with a VRAM model,
// an independent raster reference and pixel/address scoreboards.
module tb_p2_video_scan;

   localparam int unsigned HA  = 64;
   localparam int unsigned HFP = 8;
   localparam int unsigned HSY = 16;
   localparam int unsigned HBP = 24;
   localparam int unsigned VA  = 4;
   localparam int unsigned VFP = 1;
   localparam int unsigned VSY = 2;
   localparam int unsigned VBP = 2;
   localparam int unsigned LAT = 7;
   localparam int unsigned HT  = HA + HFP + HSY + HBP;
   localparam int unsigned VT  = VA + VFP + VSY + VBP;
   localparam int unsigned WPL = HA / 16;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic        video_en = 1'b0;
   logic        rd_en;
   logic [16:0] rd_addr;
   logic [15:0] rd_data = '0;
   logic        pixel, hsync, vsync, blank, vblank_irq;

   int errors = 0;
   int checks = 0;

   int unsigned rh = HT - 16, rv = VT - 1, prh = 0, prv = 0;
   bit          ref_en = 1'b0, mon_on = 1'b0;
   int unsigned cyc = 0, irq_at = 0;
   bit          irq_seen = 1'b0;
   logic        pix_q[$];
   logic [16:0] addr_q[$];
   bit          dl_v [0:LAT];
   logic [15:0] dl_d [0:LAT];

   always #5 clk = ~clk;

   p2_video_scan #(
      .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HSY), .H_BP(HBP),
      .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSY), .V_BP(VBP),
      .RD_LAT(LAT), .HS_POL(1'b0), .VS_POL(1'b0)
   ) dut (
      .clk(clk), .reset_n(reset_n), .video_en(video_en),
      .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
      .pixel(pixel), .hsync(hsync), .vsync(vsync), .blank(blank),
      .vblank_irq(vblank_irq)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [15:0] vram_word(input logic [16:0] a);
      logic [31:0] t;
      t = {16'h0, a[16:1]} * 32'h0000_9E37;
      return t[15:0] ^ 16'hC3A5;
   endfunction

   function automatic int frame_ones();
      int s = 0;
      for (int i = 0; i < int'(VA * WPL); i++)
         s += $countones(vram_word(17'(2 * i)));
      return s;
   endfunction

   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic first_read();
      int n = 0;
      while (rd_en !== 1'b1 && n < 32) begin
         step(1);
         n++;
      end
      check("first_read_latency", n, 8);
      check("first_read_addr", {15'b0, rd_addr}, 32'h0);
   endtask

   task automatic wait_irq();
      int n = 0;
      while (vblank_irq !== 1'b1 && n < int'(HT * VT + 16)) begin
         step(1);
         n++;
      end
      check("irq_arrives", {31'b0, vblank_irq}, 1);
   endtask

   // reference raster position; en sampled at frame start like the display enable
   always @(posedge clk) begin
      if (reset_n) begin
         if (rh == 0 && rv == 0) ref_en = video_en;
         prh = rh;
         prv = rv;
         if (rh == HT - 1) begin
            rh = 0;
            rv = (rv == VT - 1) ? 0 : rv + 1;
         end else begin
            rh = rh + 1;
         end
         mon_on = 1'b1;
      end
   end

   // VRAM model plus per-cycle comparison against the reference raster
   always @(negedge clk) begin
      bit          exp_rd;
      logic [16:0] exp_a;
      int unsigned k;
      logic        eb, ehs, evs, eirq, ep;
      cyc++;
      for (int i = LAT; i >= 1; i--) begin
         dl_v[i] = dl_v[i-1];
         dl_d[i] = dl_d[i-1];
      end
      dl_v[0] = (rd_en === 1'b1);
      dl_d[0] = vram_word(rd_addr);
      rd_data = dl_v[LAT] ? dl_d[LAT] : 16'($urandom);

      if (!reset_n) begin
         rh = HT - 16;
         rv = VT - 1;
         mon_on = 1'b0;
         ref_en = 1'b0;
         irq_seen = 1'b0;
         pix_q.delete();
         addr_q.delete();
      end else if (mon_on) begin
         exp_rd = 1'b0;
         exp_a  = '0;
         if (rv < VA && rh % 16 == 8 && rh <= HA - 24) begin
            exp_rd = 1'b1;
            k      = (rh + 8) / 16;
            exp_a  = 17'(2 * (rv * WPL + k));
         end
         if (rh == HT - 8 && ((rv + 1) % VT) < VA) begin
            exp_rd = 1'b1;
            exp_a  = 17'(2 * (((rv + 1) % VT) * WPL));
         end
         if (exp_rd) addr_q.push_back(exp_a);
         if (rd_en === 1'b1) begin
            if (addr_q.size() > 0)
               check($sformatf("rd_addr@v%0d,h%0d", rv, rh), {15'b0, rd_addr}, {15'b0, addr_q.pop_front()});
            else
               check($sformatf("rd_pending@v%0d,h%0d", rv, rh), addr_q.size(), 1);
            for (int b = 15; b >= 0; b--) pix_q.push_back(dl_d[0][b]);
         end

         eb   = !(prh < HA && prv < VA);
         ehs  = (prh >= HA + HFP && prh < HA + HFP + HSY) ? 1'b0 : 1'b1;
         evs  = (prv >= VA + VFP && prv < VA + VFP + VSY) ? 1'b0 : 1'b1;
         eirq = (prv == VA && prh == 0);
         check($sformatf("timing{rd,blank,hs,vs,irq}@v%0d,h%0d", prv, prh),
               {27'b0, rd_en, blank, hsync, vsync, vblank_irq},
               {27'b0, exp_rd, eb, ehs, evs, eirq});
         ep = 1'b0;
         if (!eb) begin
            if (pix_q.size() > 0)
               ep = pix_q.pop_front() & ref_en;
            else
               check($sformatf("pix_underrun@v%0d,h%0d", prv, prh), pix_q.size(), 1);
         end
         check($sformatf("pixel@v%0d,h%0d", prv, prh), {31'b0, pixel}, {31'b0, ep});

         if (vblank_irq === 1'b1) begin
            if (irq_seen) check("irq_period", cyc - irq_at, HT * VT);
            irq_seen = 1'b1;
            irq_at   = cyc;
         end
      end
   end

   initial begin
      int n, ones, reads;
      video_en = 1'b1;
      reset_n  = 1'b0;
      step(4);
      check("reset_outputs{rd,addr,pix,blank,hs,vs,irq}",
            {9'b0, rd_en, rd_addr, pixel, blank, hsync, vsync, vblank_irq},
            {9'b0, 1'b0, 17'h0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0});
      reset_n = 1'b1;
      first_read();
      step(HT * VT + 200);

      // drop enable mid-frame: current frame keeps displaying, next frame is dark
      n = 0;
      while (!(rv == 1 && rh == 20) && n < int'(2 * HT * VT)) begin
         step(1);
         n++;
      end
      video_en = 1'b0;
      wait_irq();
      ones = 0;
      reads = 0;
      repeat (HT * VT) begin
         step(1);
         if (pixel === 1'b1) ones++;
         if (rd_en === 1'b1) reads++;
      end
      check("disabled_frame_pixels", ones, 0);
      check("disabled_frame_reads", reads, VA * WPL);

      // raise enable: the following frame displays in full
      video_en = 1'b1;
      ones = 0;
      reads = 0;
      repeat (HT * VT) begin
         step(1);
         if (pixel === 1'b1) ones++;
         if (rd_en === 1'b1) reads++;
      end
      check("enabled_frame_pixels", ones, frame_ones());
      check("enabled_frame_reads", reads, VA * WPL);

      // mid-line reset one clock after the last word of line 2 is requested
      n = 0;
      while (!(rv == 2 && rh == HA - 24) && n < int'(2 * HT * VT)) begin
         step(1);
         n++;
      end
      check("inflight_read", {31'b0, rd_en}, 1);
      step(1);
      reset_n = 1'b0;
      #1;
      check("midline_reset_outputs{rd,addr,pix,blank,hs,vs,irq}",
            {9'b0, rd_en, rd_addr, pixel, blank, hsync, vsync, vblank_irq},
            {9'b0, 1'b0, 17'h0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0});
      step(1);
      reset_n = 1'b1;
      first_read();
      step(HT * VT + 100);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
